multi_hart_clint: RTL and testbench

MULTI_HART_CLINT -- requirements
Module: multi_hart_clint

---
 rtl/multi_hart_clint.sv | 166 ++++++++++++++++
 tb/tb_multi_hart_clint.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_hart_clint.sv
// Multi-hart core-local interruptor: per-hart msip/mtimecmp registers plus a shared prescaled mtime.
// Latency: one cycle from handshake to registered response (resp_valid_o or exc_valid_o).
// Backpressure: none; ready_o is high in every cycle outside reset, one request accepted per cycle.
//
// Ports:
//   clk, reset                 clock (rising edge) and asynchronous active-high reset
//   addr_i, valid_i, byte_en_i request byte address, valid strobe and access size
//   wr_i, wr_data_i            store select and store data (WORD stores use [31:0])
//   ready_o                    request accepted when valid_i & ready_o
//   data_o, resp_valid_o       load data / success strobe, one cycle after the handshake
//   exc_valid_o, exc_code_o    fault strobe and cause (7 store fault, 5 load fault)
//   msi_irq_o, mti_irq_o       per-hart software and timer interrupt levels

package multi_hart_clint_pkg;
  typedef enum logic [1:0] {
    BYTE        = 2'd0,
    HALF_WORD   = 2'd1,
    WORD        = 2'd2,
    DOUBLE_WORD = 2'd3
  } mem_access_size_t;
endpackage

module multi_hart_clint
  import multi_hart_clint_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 2,
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0001_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          addr_i,
  input  logic                 valid_i,
  input  mem_access_size_t     byte_en_i,
  input  logic                 wr_i,
  input  logic [63:0]          wr_data_i,
  output logic                 ready_o,
  output logic [63:0]          data_o,
  output logic                 resp_valid_o,
  output logic                 exc_valid_o,
  output logic [4:0]           exc_code_o,
  output logic [NUM_HARTS-1:0] msi_irq_o,
  output logic [NUM_HARTS-1:0] mti_irq_o
);

  localparam int PW = 17;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [63:0] MSIP_END  = 64'(4 * NUM_HARTS);
  localparam logic [63:0] CMP_BASE  = 64'h4000;
  localparam logic [63:0] CMP_END   = 64'h4000 + 64'(8 * NUM_HARTS);
  localparam logic [63:0] MTIME_OFF = 64'hBFF8;
  localparam logic [4:0]  EXC_LOAD  = 5'd5;
  localparam logic [4:0]  EXC_STORE = 5'd7;

  logic [NUM_HARTS-1:0] msip_q, msip_d;
  logic [63:0]          mtimecmp_q [NUM_HARTS];
  logic [63:0]          mtimecmp_d [NUM_HARTS];
  logic [63:0]          mtime_q, mtime_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 exc_valid_q, exc_valid_d;
  logic [4:0]           exc_code_q, exc_code_d;
  logic [63:0]          data_q, data_d;

  logic [63:0] off;
  logic        in_base, hit_msip, hit_cmp, hit_mtime;
  logic        msip_ok, wide_ok, legal, req, wr_ok, tick;
  logic        is_word, sel_hi;
  logic [5:0]  hart;
  logic        msip_bit;
  logic [63:0] reg64, rd_val, wr64;

  assign off       = addr_i - BASE_ADDR;
  assign in_base   = addr_i >= BASE_ADDR;
  assign hit_msip  = in_base && (off < MSIP_END);
  assign hit_cmp   = in_base && (off >= CMP_BASE) && (off < CMP_END);
  assign hit_mtime = in_base && (off[63:3] == MTIME_OFF[63:3]);
  // CMP_BASE is 512-byte aligned, so the mtimecmp hart index is simply off[8:3].
  assign hart      = hit_msip ? off[7:2] : off[8:3];
  assign is_word   = (byte_en_i == WORD);
  assign sel_hi    = off[2];

  assign msip_ok = hit_msip && (off[1:0] == 2'b00) && is_word;
  assign wide_ok = (hit_cmp || hit_mtime) &&
                   (((off[2:0] == 3'd0) && (is_word || (byte_en_i == DOUBLE_WORD))) ||
                    ((off[2:0] == 3'd4) && is_word));
  assign legal   = msip_ok || wide_ok;
  assign ready_o = ~reset;
  assign req     = valid_i && ready_o;
  assign wr_ok   = req && legal && wr_i;
  assign tick    = (presc_q == PRESC_MAX);

  // Select the addressed register; index compared per hart to stay width-clean for any NUM_HARTS.
  always_comb begin
    msip_bit = 1'b0;
    reg64    = mtime_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (hart == 6'(h)) begin
        msip_bit = msip_q[h];
        if (hit_cmp) reg64 = mtimecmp_q[h];
      end
    end
  end

  always_comb begin
    rd_val = reg64;
    if (msip_ok)      rd_val = {63'b0, msip_bit};
    else if (is_word) rd_val = sel_hi ? {32'b0, reg64[63:32]} : {32'b0, reg64[31:0]};
    // WORD stores merge into the untouched half of the current value.
    wr64 = wr_data_i;
    if (is_word) wr64 = sel_hi ? {wr_data_i[31:0], reg64[31:0]} : {reg64[63:32], wr_data_i[31:0]};
  end

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (wr_ok && msip_ok && (hart == 6'(h))) msip_d[h] = wr_data_i[0];
      if (wr_ok && hit_cmp && (hart == 6'(h))) mtimecmp_d[h] = wr64;
    end
    // An mtime store overrides this cycle's increment and restarts the prescaler.
    if (wr_ok && hit_mtime) begin
      mtime_d = wr64;
      presc_d = '0;
    end
    resp_valid_d = req && legal;
    exc_valid_d  = req && !legal;
    exc_code_d   = (req && !legal) ? (wr_i ? EXC_STORE : EXC_LOAD) : 5'd0;
    data_d       = (req && legal && !wr_i) ? rd_val : 64'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msip_q       <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp_q[h] <= '1;
      mtime_q      <= '0;
      presc_q      <= '0;
      resp_valid_q <= 1'b0;
      exc_valid_q  <= 1'b0;
      exc_code_q   <= '0;
      data_q       <= '0;
    end else begin
      msip_q       <= msip_d;
      mtimecmp_q   <= mtimecmp_d;
      mtime_q      <= mtime_d;
      presc_q      <= presc_d;
      resp_valid_q <= resp_valid_d;
      exc_valid_q  <= exc_valid_d;
      exc_code_q   <= exc_code_d;
      data_q       <= data_d;
    end
  end

  assign data_o       = data_q;
  assign resp_valid_o = resp_valid_q;
  assign exc_valid_o  = exc_valid_q;
  assign exc_code_o   = exc_code_q;
  assign msi_irq_o    = msip_q;

  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) mti_irq_o[h] = (mtime_q >= mtimecmp_q[h]);
  end

endmodule

// File: tb/tb_multi_hart_clint.sv
`timescale 1ns/1ps
module tb_multi_hart_clint;
  import multi_hart_clint_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
  localparam int NH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [63:0]      addr_i;
  logic             valid_i;
  mem_access_size_t byte_en_i;
  logic             wr_i;
  logic [63:0]      wr_data_i;

  // Index 0: TICK_DIV=1 instance, index 1: TICK_DIV=4 instance; both see the same requests.
  logic          ready_w [2];
  logic [63:0]   data_w  [2];
  logic          resp_w  [2];
  logic          exc_w   [2];
  logic [4:0]    code_w  [2];
  logic [NH-1:0] msi_w   [2];
  logic [NH-1:0] mti_w   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_hart_clint #(.NUM_HARTS(NH), .TICK_DIV(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .reset(reset), .addr_i(addr_i), .valid_i(valid_i), .byte_en_i(byte_en_i),
    .wr_i(wr_i), .wr_data_i(wr_data_i), .ready_o(ready_w[0]), .data_o(data_w[0]),
    .resp_valid_o(resp_w[0]), .exc_valid_o(exc_w[0]), .exc_code_o(code_w[0]),
    .msi_irq_o(msi_w[0]), .mti_irq_o(mti_w[0]));

  multi_hart_clint #(.NUM_HARTS(NH), .TICK_DIV(4), .BASE_ADDR(BASE)) u_dut4 (
    .clk(clk), .reset(reset), .addr_i(addr_i), .valid_i(valid_i), .byte_en_i(byte_en_i),
    .wr_i(wr_i), .wr_data_i(wr_data_i), .ready_o(ready_w[1]), .data_o(data_w[1]),
    .resp_valid_o(resp_w[1]), .exc_valid_o(exc_w[1]), .exc_code_o(code_w[1]),
    .msi_irq_o(msi_w[1]), .mti_irq_o(mti_w[1]));

  // ---------------- reference model ----------------
  // mtime is modelled as "value at last anchor + elapsed cycles / TICK_DIV"; an anchor is
  // the first cycle after reset or after an mtime store.
  int unsigned     td [2] = '{1, 4};
  longint unsigned cyc;
  logic [NH-1:0]   m_msip;
  logic [63:0]     m_cmp [NH];
  logic [63:0]     m_anchor_val [2];
  longint unsigned m_anchor_cyc [2];

  logic          e_resp [2];
  logic          e_exc  [2];
  logic [4:0]    e_code [2];
  logic [63:0]   e_data [2];
  logic [NH-1:0] e_mti  [2];
  logic [NH-1:0] e_msi;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [63:0] m_mtime(input int i);
    return m_anchor_val[i] + 64'((cyc - m_anchor_cyc[i]) / longint'(td[i]));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] d, input int part);
    if (part == 1) return {cur[63:32], d[31:0]};
    if (part == 2) return {d[31:0], cur[31:0]};
    return d;
  endfunction

  // kind: 0 fault, 1 msip, 2 mtimecmp, 3 mtime; part: 0 full, 1 low word, 2 high word
  function automatic void decode(input logic [63:0] a, input mem_access_size_t sz,
                                 output int kind, output int h, output int part);
    logic [63:0] off;
    int region;
    kind = 0; h = 0; part = 0; region = 0;
    if (a < BASE) return;
    off = a - BASE;
    if (off < 64'(4 * NH)) begin
      if ((off % 4 == 0) && (sz == WORD)) begin kind = 1; h = int'(off / 4); end
      return;
    end
    if (off >= 64'h4000 && off < 64'h4000 + 64'(8 * NH)) begin
      region = 2; h = int'((off - 64'h4000) / 8);
    end else if (off >= 64'hBFF8 && off < 64'hC000) begin
      region = 3;
    end
    if (region == 0) return;
    if ((off % 8 == 0) && (sz == DOUBLE_WORD)) begin kind = region; part = 0; end
    else if ((off % 8 == 0) && (sz == WORD)) begin kind = region; part = 1; end
    else if ((off % 8 == 4) && (sz == WORD)) begin kind = region; part = 2; end
  endfunction

  function automatic void model_reset();
    m_msip = '0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
    for (int i = 0; i < 2; i++) begin m_anchor_val[i] = '0; m_anchor_cyc[i] = 0; end
  endfunction

  // Drives one cycle (starting at a negedge), advances the model, returns at the next negedge
  // with e_* holding what the DUT outputs should show.
  task automatic step(input logic v, input logic [63:0] a, input mem_access_size_t sz,
                      input logic w, input logic [63:0] d);
    int kind, h, part;
    logic [63:0] cur;
    longint unsigned c;
    valid_i = v; addr_i = a; byte_en_i = sz; wr_i = w; wr_data_i = d;
    decode(a, sz, kind, h, part);
    c = cyc;
    for (int i = 0; i < 2; i++) begin
      e_resp[i] = v && (kind != 0);
      e_exc[i]  = v && (kind == 0);
      e_code[i] = (v && kind == 0) ? (w ? 5'd7 : 5'd5) : 5'd0;
      cur = (kind == 2) ? m_cmp[h] : m_mtime(i);
      if (!v || w || kind == 0) e_data[i] = '0;
      else if (kind == 1)       e_data[i] = {63'b0, m_msip[h]};
      else if (part == 1)       e_data[i] = {32'b0, cur[31:0]};
      else if (part == 2)       e_data[i] = {32'b0, cur[63:32]};
      else                      e_data[i] = cur;
      if (v && w && kind == 3) begin
        m_anchor_val[i] = merge(cur, d, part);
        m_anchor_cyc[i] = c + 1;
      end
    end
    if (v && w && kind == 1) m_msip[h] = d[0];
    if (v && w && kind == 2) m_cmp[h] = merge(m_cmp[h], d, part);
    @(posedge clk);
    @(negedge clk);
    e_msi = m_msip;
    for (int i = 0; i < 2; i++)
      for (int hh = 0; hh < NH; hh++) e_mti[i][hh] = (m_mtime(i) >= m_cmp[hh]);
  endtask

  task automatic apply_reset();
    reset = 1'b1; valid_i = 1'b0; addr_i = '0; byte_en_i = BYTE; wr_i = 1'b0; wr_data_i = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; valid_i = 1'b1; addr_i = BASE; byte_en_i = WORD; wr_i = 1'b0; wr_data_i = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (ready_w[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ready inst%0d: got %b want 0", i, ready_w[i]); end
      n_chk++; if (resp_w[i] !== 1'b0 || exc_w[i] !== 1'b0 || code_w[i] !== 5'd0 || data_w[i] !== 64'd0) begin
        n_fail++; $display("FAIL reset_resp inst%0d: got resp=%b exc=%b code=%0d data=%h want all 0", i, resp_w[i], exc_w[i], code_w[i], data_w[i]);
      end
      n_chk++; if (msi_w[i] !== 2'b00 || mti_w[i] !== 2'b00) begin
        n_fail++; $display("FAIL reset_irq inst%0d: got msi=%b mti=%b want 00/00", i, msi_w[i], mti_w[i]);
      end
    end
    valid_i = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    n_chk++; if (ready_w[0] !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", ready_w[0]); end
    step(1'b1, BASE + 64'h4008, DOUBLE_WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_mtimecmp1: got %h want ffffffffffffffff", data_w[0]); end
    step(1'b1, BASE + 64'hBFF8, DOUBLE_WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'd1 || data_w[1] !== 64'd0) begin n_fail++; $display("FAIL reset_mtime: got %h/%h want 1/0", data_w[0], data_w[1]); end
  endtask

  task automatic test_msip();
    apply_reset();
    step(1'b1, BASE + 64'h4, WORD, 1'b1, 64'd1);
    n_chk++; if (resp_w[0] !== 1'b1 || exc_w[0] !== 1'b0) begin n_fail++; $display("FAIL msip_store_resp: got resp=%b exc=%b want 1/0", resp_w[0], exc_w[0]); end
    n_chk++; if (msi_w[0] !== 2'b10) begin n_fail++; $display("FAIL msip_irq: got %b want 10", msi_w[0]); end
    n_chk++; if (data_w[0] !== 64'd0) begin n_fail++; $display("FAIL msip_store_data: got %h want 0", data_w[0]); end
    step(1'b1, BASE + 64'h4, WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'd1 || resp_w[0] !== 1'b1) begin n_fail++; $display("FAIL msip_load: got data=%h resp=%b want 1/1", data_w[0], resp_w[0]); end
    // Only bit 0 of the store data matters.
    step(1'b1, BASE, WORD, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    n_chk++; if (msi_w[0] !== 2'b10) begin n_fail++; $display("FAIL msip_bit0_only: got %b want 10", msi_w[0]); end
  endtask

  task automatic test_prescaler();
    apply_reset();
    for (int k = 0; k < 12; k++) step(1'b0, '0, BYTE, 1'b0, '0);
    step(1'b1, BASE + 64'hBFF8, DOUBLE_WORD, 1'b0, '0);
    n_chk++; if (resp_w[1] !== 1'b1 || data_w[1] !== 64'd3) begin n_fail++; $display("FAIL presc_div4: got resp=%b data=%h want 1/3", resp_w[1], data_w[1]); end
    n_chk++; if (data_w[0] !== 64'd12) begin n_fail++; $display("FAIL presc_div1: got %h want 12", data_w[0]); end
    step(1'b0, '0, BYTE, 1'b0, '0);
    n_chk++; if (resp_w[1] !== 1'b0 || data_w[1] !== 64'd0) begin n_fail++; $display("FAIL resp_single_cycle: got resp=%b data=%h want 0/0", resp_w[1], data_w[1]); end
  endtask

  task automatic test_timer_irq();
    apply_reset();
    step(1'b1, BASE + 64'h4000, DOUBLE_WORD, 1'b1, 64'd20);
    for (int k = 0; k < 24; k++) begin
      step(1'b0, '0, BYTE, 1'b0, '0);
      n_chk++; if (mti_w[0] !== e_mti[0] || mti_w[1] !== e_mti[1]) begin
        n_fail++; $display("FAIL mti_track k=%0d: got %b/%b want %b/%b", k, mti_w[0], mti_w[1], e_mti[0], e_mti[1]);
      end
      if (k == 17) begin n_chk++; if (mti_w[0] !== 2'b00) begin n_fail++; $display("FAIL mti_at_19: got %b want 00", mti_w[0]); end end
      if (k == 18) begin n_chk++; if (mti_w[0] !== 2'b01) begin n_fail++; $display("FAIL mti_at_20: got %b want 01", mti_w[0]); end end
    end
  endtask

  task automatic test_word_half();
    apply_reset();
    step(1'b1, BASE + 64'h4004, WORD, 1'b1, 64'h1234_5678_DEAD_BEEF);
    n_chk++; if (resp_w[0] !== 1'b1) begin n_fail++; $display("FAIL word_store_resp: got %b want 1", resp_w[0]); end
    step(1'b1, BASE + 64'h4000, DOUBLE_WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'hDEAD_BEEF_FFFF_FFFF) begin n_fail++; $display("FAIL word_merge: got %h want deadbeefffffffff", data_w[0]); end
    step(1'b1, BASE + 64'h4004, WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'h0000_0000_DEAD_BEEF) begin n_fail++; $display("FAIL word_hi_load: got %h want 00000000deadbeef", data_w[0]); end
    step(1'b1, BASE + 64'h4000, WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL word_lo_load: got %h want 00000000ffffffff", data_w[0]); end
  endtask

  typedef struct {
    logic [63:0]      off;
    mem_access_size_t sz;
    logic             w;
  } flt_t;

  task automatic test_faults();
    flt_t tbl [10] = '{
      '{64'hBFF8, HALF_WORD, 1'b1}, '{64'h8, WORD, 1'b0}, '{64'h4002, WORD, 1'b0},
      '{64'h0, BYTE, 1'b1}, '{64'h4010, DOUBLE_WORD, 1'b0}, '{64'hC000, DOUBLE_WORD, 1'b0},
      '{64'hFFFF_FFFF_FFFF_FFF8, DOUBLE_WORD, 1'b0}, '{64'h4004, DOUBLE_WORD, 1'b1},
      '{64'h2, WORD, 1'b1}, '{64'h0, DOUBLE_WORD, 1'b0}};
    apply_reset();
    foreach (tbl[t]) begin
      step(1'b1, BASE + tbl[t].off, tbl[t].sz, tbl[t].w, 64'h5);
      n_chk++; if (exc_w[0] !== 1'b1 || resp_w[0] !== 1'b0 || data_w[0] !== 64'd0) begin
        n_fail++; $display("FAIL fault_flags t=%0d: got exc=%b resp=%b data=%h want 1/0/0", t, exc_w[0], resp_w[0], data_w[0]);
      end
      n_chk++; if (code_w[0] !== (tbl[t].w ? 5'd7 : 5'd5)) begin
        n_fail++; $display("FAIL fault_code t=%0d: got %0d want %0d", t, code_w[0], tbl[t].w ? 7 : 5);
      end
    end
    step(1'b1, BASE + 64'hBFF8, DOUBLE_WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== e_data[0] || data_w[1] !== e_data[1]) begin
      n_fail++; $display("FAIL fault_no_side_effect: got %h/%h want %h/%h", data_w[0], data_w[1], e_data[0], e_data[1]);
    end
    n_chk++; if (msi_w[0] !== 2'b00) begin n_fail++; $display("FAIL fault_msip_untouched: got %b want 00", msi_w[0]); end
  endtask

  task automatic test_wrap();
    apply_reset();
    step(1'b1, BASE + 64'h4000, DOUBLE_WORD, 1'b1, 64'd20);
    step(1'b1, BASE + 64'hBFF8, DOUBLE_WORD, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    n_chk++; if (mti_w[0][0] !== 1'b1) begin n_fail++; $display("FAIL wrap_pre: got %b want 1", mti_w[0][0]); end
    step(1'b0, '0, BYTE, 1'b0, '0);
    n_chk++; if (mti_w[0][0] !== 1'b1) begin n_fail++; $display("FAIL wrap_allones: got %b want 1", mti_w[0][0]); end
    step(1'b0, '0, BYTE, 1'b0, '0);
    n_chk++; if (mti_w[0][0] !== 1'b0) begin n_fail++; $display("FAIL wrap_zero_irq: got %b want 0", mti_w[0][0]); end
    step(1'b1, BASE + 64'hBFF8, DOUBLE_WORD, 1'b0, '0);
    n_chk++; if (data_w[0] !== 64'd0 || data_w[1] !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      n_fail++; $display("FAIL wrap_value: got %h/%h want 0/fffffffffffffffe", data_w[0], data_w[1]);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [63:0] offs [16] = '{64'h0, 64'h4, 64'h8, 64'h1, 64'h4000, 64'h4004, 64'h4008, 64'h400C,
                               64'h4010, 64'h4002, 64'hBFF8, 64'hBFFC, 64'hC000, 64'hBFF0,
                               64'h2000, 64'hFFFF_FFFF_FFFF_FFF8};
    logic [63:0] d;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      d = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 400));
      step($urandom_range(0, 4) != 0, BASE + offs[$urandom_range(0, 15)],
           mem_access_size_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d);
      for (int i = 0; i < 2; i++) begin
        n_chk++; if (resp_w[i] !== e_resp[i] || exc_w[i] !== e_exc[i] || code_w[i] !== e_code[i] || ready_w[i] !== 1'b1) begin
          n_fail++; $display("FAIL rnd_status n=%0d inst%0d: got resp=%b exc=%b code=%0d rdy=%b want %b/%b/%0d/1",
                             n, i, resp_w[i], exc_w[i], code_w[i], ready_w[i], e_resp[i], e_exc[i], e_code[i]);
        end
        n_chk++; if (data_w[i] !== e_data[i]) begin n_fail++; $display("FAIL rnd_data n=%0d inst%0d: got %h want %h", n, i, data_w[i], e_data[i]); end
        n_chk++; if (msi_w[i] !== e_msi || mti_w[i] !== e_mti[i]) begin
          n_fail++; $display("FAIL rnd_irq n=%0d inst%0d: got msi=%b mti=%b want %b/%b", n, i, msi_w[i], mti_w[i], e_msi, e_mti[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    apply_reset();
    valid_i = 1'b1; addr_i = BASE + 64'hBFF8; byte_en_i = DOUBLE_WORD; wr_i = 1'b0; wr_data_i = '0;
    @(posedge clk); #1;
    n_chk++; if (resp_w[0] !== 1'b1) begin n_fail++; $display("FAIL midop_pending: got %b want 1", resp_w[0]); end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (resp_w[i] !== 1'b0 || exc_w[i] !== 1'b0 || data_w[i] !== 64'd0 || ready_w[i] !== 1'b0) begin
        n_fail++; $display("FAIL midop_discard inst%0d: got resp=%b exc=%b data=%h rdy=%b want 0/0/0/0", i, resp_w[i], exc_w[i], data_w[i], ready_w[i]);
      end
    end
    valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1'b0, '0, BYTE, 1'b0, '0);
    n_chk++; if (resp_w[0] !== 1'b0 || exc_w[0] !== 1'b0) begin n_fail++; $display("FAIL midop_no_late_resp: got resp=%b exc=%b want 0/0", resp_w[0], exc_w[0]); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_msip();
    test_prescaler();
    test_timer_irq();
    test_word_half();
    test_faults();
    test_wrap();
    test_back_to_back_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
